// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-outstanding memory port between the instruction-fetch
// requester (IFU) and the load/store requester (LSU). Every channel uses a
// valid/ready handshake.
//
// The LSU has fixed priority. A starvation guard counts consecutive LSU wins
// taken while the IFU was also waiting. Once that count reaches STARVE_MAX, the
// next contested grant goes to the IFU.
//
// Every memory-side output is decoded from the state register or driven from a
// latch register. There is therefore no combinational path from the memory
// side to either requester. The only combinational outputs are the two
// req_ready signals. Each of them depends on the requester valids and on state
// that is already registered.
//
// Transaction flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//   IDLE  : pick a winner, assert its req_ready, latch the request fields
//   ISSUE : present the latched request to memory until mem_req_ready
//   WAIT  : accept the memory response and latch its read data
//   RESP  : present the response to the owner until the owner takes it
//
// Parameters:
//   ADDR_W     address width
//   DATA_W     data width (byte mask is DATA_W/8 bits)
//   STARVE_MAX consecutive contested LSU grants before the IFU is forced (1..15)
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   ifu_req_*             IFU read request  (valid/ready, addr)
//   ifu_resp_*            IFU read response (valid/ready, rdata)
//   lsu_req_*             LSU request  (valid/ready, addr, wen, wdata, wmask)
//   lsu_resp_*            LSU response (valid/ready, rdata); writes respond too
//   mem_req_*             request to memory, driven from latch registers
//   mem_resp_*            response from memory
//   owner                 00 none, 01 IFU, 10 LSU
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_W-1:0]     ifu_resp_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_W-1:0]     lsu_req_wdata,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_W-1:0]     lsu_resp_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_resp_rdata,

  output logic [1:0]            owner
);

  localparam int         MASK_W     = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  owner_next;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;

  // Latched request fields and the latched response data.
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;

  // Winner selection. These signals only take effect in IDLE. The LSU yields
  // only when the IFU is waiting and the starvation limit has been reached.
  logic ifu_forced;
  logic grant_lsu;
  logic grant_ifu;
  logic resp_taken;

  assign ifu_forced = ifu_req_valid && (starve_cnt == STARVE_LIM);
  assign grant_lsu  = lsu_req_valid && !ifu_forced;
  assign grant_ifu  = ifu_req_valid && !grant_lsu;

  // Only the current owner's resp_ready can close the transaction.
  assign resp_taken = ((owner == OWN_IFU) && ifu_resp_ready) ||
                      ((owner == OWN_LSU) && lsu_resp_ready);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so that every register
  // samples the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      starve_cnt <= starve_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each signal written here gets a default first. Any path through the
    // case that does not assign a signal then holds the default, so no latch
    // is inferred.
    state_next     = state;
    owner_next     = owner;
    starve_next    = starve_cnt;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_lsu) begin
          lsu_req_ready = 1'b1;
          owner_next    = OWN_LSU;
          state_next    = ISSUE;
          // A contested LSU win adds to the IFU's wait, saturating at the
          // limit. An uncontested win means the IFU is not waiting, so the
          // count restarts.
          if (ifu_req_valid) begin
            starve_next = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
          end else begin
            starve_next = '0;
          end
        end else if (grant_ifu) begin
          ifu_req_ready = 1'b1;
          owner_next    = OWN_IFU;
          state_next    = ISSUE;
          starve_next   = '0;
        end
      end

      ISSUE: begin
        // mem_req_valid is decoded from the state register. It therefore
        // stays high until the cycle in which memory accepts the request.
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          state_next = RESP;
        end
      end

      RESP: begin
        ifu_resp_valid = (owner == OWN_IFU);
        lsu_resp_valid = (owner == OWN_LSU);
        if (resp_taken) begin
          owner_next = OWN_NONE;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request / response latches
  // ---------------------------------------------------------------------------
  // Request fields are captured only on the granting handshake. Requester
  // inputs are therefore ignored for the rest of the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (lsu_req_ready) begin
        addr_q  <= lsu_req_addr;
        wen_q   <= lsu_req_wen;
        wdata_q <= lsu_req_wdata;
        wmask_q <= lsu_req_wmask;
      end else if (ifu_req_ready) begin
        addr_q  <= ifu_req_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end

      if (mem_resp_ready && mem_resp_valid) begin
        rdata_q <= mem_resp_rdata;
      end
    end
  end

  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;

  // Both requesters see the same latched data. Only the owner's valid is
  // raised, so the non-owner never consumes it.
  assign ifu_resp_rdata = rdata_q;
  assign lsu_resp_rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Protocol assertions
  // ---------------------------------------------------------------------------
  a_one_req_ready: assert property (@(posedge clk) disable iff (reset)
    !(ifu_req_ready && lsu_req_ready));

  a_one_resp_valid: assert property (@(posedge clk) disable iff (reset)
    !(ifu_resp_valid && lsu_resp_valid));

  a_mem_req_stable: assert property (@(posedge clk) disable iff (reset)
    (mem_req_valid && !mem_req_ready) |=>
      (mem_req_valid && $stable(mem_req_addr) && $stable(mem_req_wen) &&
       $stable(mem_req_wdata) && $stable(mem_req_wmask)));

endmodule
